// File: rtl/csr_timer.sv
// Machine timer on the CSR bus: 64-bit mtime with prescaled tick, 64-bit mtimecmp
// and a level timer interrupt.
module csr_timer #(
   parameter logic [11:0] BASE_ADDR  = 12'h7c2,
   parameter int          CLOCK_RATE = 12_000_000,
   parameter int          TICK_RATE  = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic [2:0]  modify,
   input  logic [31:0] wdata,
   input  logic [11:0] addr,
   output logic [31:0] rdata,
   output logic        valid,
   output logic        irq_timer
);

   localparam int          PRE_RST_I = CLOCK_RATE / TICK_RATE - 1;
   localparam logic [15:0] PRE_RST   = PRE_RST_I[15:0];

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        en_q, en_d;
   logic [15:0] pre_q, pre_d;
   logic [15:0] cnt_q, cnt_d;
   logic        irq_q, irq_d;

   logic [11:0] off_s;
   logic        hit_s;
   logic        wr_s;
   logic        tick_s;
   logic [31:0] cur_s;
   logic [31:0] wval_s;

   // Decode, read mux and combined write/tick next-state logic.
   always_comb begin
      off_s = addr - BASE_ADDR;
      hit_s = (off_s < 12'd5);
      case (off_s)
         12'd0:   cur_s = mtime_q[31:0];
         12'd1:   cur_s = mtime_q[63:32];
         12'd2:   cur_s = mtimecmp_q[31:0];
         12'd3:   cur_s = mtimecmp_q[63:32];
         12'd4:   cur_s = {pre_q, 15'd0, en_q};
         default: cur_s = 32'd0;
      endcase
      rdata = hit_s ? cur_s : 32'd0;
      valid = hit_s & (read | (modify != 3'b000));

      wr_s = 1'b0;
      case (modify)
         3'b001: begin wval_s = wdata;          wr_s = hit_s; end
         3'b010: begin wval_s = cur_s | wdata;  wr_s = hit_s; end
         3'b011: begin wval_s = cur_s & ~wdata; wr_s = hit_s; end
         default: wval_s = cur_s;
      endcase

      tick_s     = en_q & (cnt_q == pre_q);
      cnt_d      = (!en_q || tick_s) ? 16'd0 : cnt_q + 16'd1;
      // The increment (and its carry) uses the pre-write value; a written half overrides it.
      mtime_d    = mtime_q + {63'd0, tick_s};
      mtimecmp_d = mtimecmp_q;
      en_d       = en_q;
      pre_d      = pre_q;
      if (wr_s) begin
         case (off_s)
            12'd0: mtime_d[31:0]     = wval_s;
            12'd1: mtime_d[63:32]    = wval_s;
            12'd2: mtimecmp_d[31:0]  = wval_s;
            12'd3: mtimecmp_d[63:32] = wval_s;
            12'd4: begin
               en_d  = wval_s[0];
               pre_d = wval_s[31:16];
               cnt_d = 16'd0;
            end
            default: begin
               en_d = en_q;
            end
         endcase
      end else begin
         en_d = en_q;
      end
      irq_d = en_d & (mtime_d >= mtimecmp_d);
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime_q    <= 64'd0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         en_q       <= 1'b0;
         pre_q      <= PRE_RST;
         cnt_q      <= 16'd0;
         irq_q      <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         en_q       <= en_d;
         pre_q      <= pre_d;
         cnt_q      <= cnt_d;
         irq_q      <= irq_d;
      end
   end

   assign irq_timer = irq_q;

endmodule

// File: tb/tb_csr_timer.sv
// Self-checking bench for csr_timer: decode table, then timed sequences for
// prescaler, carry, wrap, interrupt, set/clear and reset corners.
module tb_csr_timer;

   logic        clk;
   logic        rst;
   logic        read;
   logic [2:0]  modify;
   logic [31:0] wdata;
   logic [11:0] addr;
   logic [31:0] rdata;
   logic        valid;
   logic        irq_timer;

   csr_timer dut (
      .clk       (clk),
      .rst       (rst),
      .read      (read),
      .modify    (modify),
      .wdata     (wdata),
      .addr      (addr),
      .rdata     (rdata),
      .valid     (valid),
      .irq_timer (irq_timer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic [2:0]  md;
      logic [31:0] wd;
      logic [11:0] ad;
      logic        ev;
      logic        cr;
      logic [31:0] er;
   } vec_t;

   typedef struct {
      logic        ev;
      logic        cr;
      logic [31:0] er;
      string       nm;
   } exp_t;

   exp_t sb[$];
   exp_t ce;
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t tbl[15];

   // Scoreboard: compare the outputs of each driven access mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         ce = sb.pop_front();
         n_cmp++;
         if (valid !== ce.ev) begin
            n_bad++;
            $display("FAIL %s valid: got %0b want %0b", ce.nm, valid, ce.ev);
         end
         if (ce.cr) begin
            n_cmp++;
            if (rdata !== ce.er) begin
               n_bad++;
               $display("FAIL %s rdata: got %h want %h", ce.nm, rdata, ce.er);
            end
         end
      end
   end

   task automatic acc(input logic rd_i, input logic [2:0] md_i, input logic [31:0] wd_i,
                      input logic [11:0] ad_i, input logic ev_i, input logic cr_i,
                      input logic [31:0] er_i, input string nm);
      read   = rd_i;
      modify = md_i;
      wdata  = wd_i;
      addr   = ad_i;
      sb.push_back('{ev_i, cr_i, er_i, nm});
      @(posedge clk);
      #1;
      read   = 1'b0;
      modify = 3'b000;
      wdata  = 32'd0;
      addr   = 12'h000;
   endtask

   task automatic wr(input logic [11:0] ad_i, input logic [31:0] wd_i, input string nm);
      acc(1'b0, 3'b001, wd_i, ad_i, 1'b1, 1'b0, 32'd0, nm);
   endtask

   task automatic rd(input logic [11:0] ad_i, input logic [31:0] er_i, input string nm);
      acc(1'b1, 3'b000, 32'd0, ad_i, 1'b1, 1'b1, er_i, nm);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input logic [63:0] got, input logic [63:0] want, input string nm);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   initial begin
      tbl[0]  = '{1'b1, 3'b000, 32'd0,          12'h7c2, 1'b1, 1'b1, 32'h0000_0000};
      tbl[1]  = '{1'b1, 3'b000, 32'd0,          12'h7c3, 1'b1, 1'b1, 32'h0000_0000};
      tbl[2]  = '{1'b1, 3'b000, 32'd0,          12'h7c4, 1'b1, 1'b1, 32'hFFFF_FFFF};
      tbl[3]  = '{1'b1, 3'b000, 32'd0,          12'h7c5, 1'b1, 1'b1, 32'hFFFF_FFFF};
      tbl[4]  = '{1'b1, 3'b000, 32'd0,          12'h7c6, 1'b1, 1'b1, 32'h000B_0000};
      tbl[5]  = '{1'b1, 3'b000, 32'd0,          12'h7c7, 1'b0, 1'b1, 32'h0000_0000};
      tbl[6]  = '{1'b1, 3'b000, 32'd0,          12'h7c1, 1'b0, 1'b1, 32'h0000_0000};
      tbl[7]  = '{1'b0, 3'b000, 32'd0,          12'h7c4, 1'b0, 1'b1, 32'hFFFF_FFFF};
      tbl[8]  = '{1'b0, 3'b100, 32'd0,          12'h7c4, 1'b1, 1'b1, 32'hFFFF_FFFF};
      tbl[9]  = '{1'b1, 3'b000, 32'd0,          12'h7c4, 1'b1, 1'b1, 32'hFFFF_FFFF};
      tbl[10] = '{1'b0, 3'b001, 32'h0000_FFFE,  12'h7c6, 1'b1, 1'b1, 32'h000B_0000};
      tbl[11] = '{1'b1, 3'b000, 32'd0,          12'h7c6, 1'b1, 1'b1, 32'h0000_0000};
      tbl[12] = '{1'b0, 3'b001, 32'h000B_0000,  12'h7c6, 1'b1, 1'b1, 32'h0000_0000};
      tbl[13] = '{1'b1, 3'b000, 32'd0,          12'h7c6, 1'b1, 1'b1, 32'h000B_0000};
      tbl[14] = '{1'b1, 3'b000, 32'd0,          12'h7c2, 1'b1, 1'b1, 32'h0000_0000};

      rst = 1'b1; read = 1'b0; modify = 3'b000; wdata = 32'd0; addr = 12'h000;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk({63'd0, irq_timer}, 64'd0, "rst_irq");
      idle(30);
      acc(1'b0, 3'b000, 32'd0, 12'h000, 1'b0, 1'b1, 32'd0, "idle_out");
      chk({63'd0, irq_timer}, 64'd0, "idle_irq");

      for (int i = 0; i < 15; i++)
         acc(tbl[i].rd, tbl[i].md, tbl[i].wd, tbl[i].ad, tbl[i].ev, tbl[i].cr, tbl[i].er,
             $sformatf("tbl%0d", i));

      // Prescale 0 then 3.
      acc(1'b0, 3'b001, 32'h0000_0001, 12'h7c6, 1'b1, 1'b1, 32'h000B_0000, "en_wr");
      idle(10);
      rd(12'h7c2, 32'd10, "pre0_10");
      acc(1'b0, 3'b001, 32'h0003_0001, 12'h7c6, 1'b1, 1'b1, 32'h0000_0001, "pre3_wr");
      rd(12'h7c2, 32'd12, "pre3_a");
      idle(2);
      rd(12'h7c2, 32'd12, "pre3_b");
      rd(12'h7c2, 32'd13, "pre3_c");
      idle(3);
      rd(12'h7c2, 32'd14, "pre3_d");

      // Low-to-high carry and full 64-bit wrap.
      wr(12'h7c6, 32'd0, "dis");
      wr(12'h7c2, 32'hFFFF_FFFE, "c_lo");
      wr(12'h7c3, 32'd0, "c_hi");
      wr(12'h7c6, 32'd1, "c_en");
      idle(2);
      rd(12'h7c2, 32'd0, "carry_lo");
      rd(12'h7c3, 32'd1, "carry_hi");
      wr(12'h7c6, 32'd0, "dis");
      wr(12'h7c2, 32'hFFFF_FFFF, "w_lo");
      wr(12'h7c3, 32'hFFFF_FFFF, "w_hi");
      wr(12'h7c6, 32'd1, "w_en");
      idle(1);
      rd(12'h7c2, 32'd0, "wrap_lo");
      rd(12'h7c3, 32'd0, "wrap_hi");

      // Interrupt at mtime == mtimecmp, dropped by raising cmp.
      wr(12'h7c6, 32'd0, "dis");
      wr(12'h7c2, 32'd0, "i_lo");
      wr(12'h7c3, 32'd0, "i_hi");
      wr(12'h7c5, 32'd0, "cmp_hi");
      wr(12'h7c4, 32'd20, "cmp_lo");
      chk({63'd0, irq_timer}, 64'd0, "irq_dis");
      wr(12'h7c6, 32'd1, "i_en");
      idle(19);
      chk({63'd0, irq_timer}, 64'd0, "irq_19");
      idle(1);
      chk({63'd0, irq_timer}, 64'd1, "irq_20");
      rd(12'h7c2, 32'd20, "irq_mtime");
      idle(3);
      chk({63'd0, irq_timer}, 64'd1, "irq_hold");
      wr(12'h7c5, 32'd1, "cmp_raise");
      chk({63'd0, irq_timer}, 64'd0, "irq_drop");

      // Set/clear with read-old, and freeze while disabled.
      wr(12'h7c6, 32'd0, "dis");
      acc(1'b0, 3'b010, 32'd1, 12'h7c6, 1'b1, 1'b1, 32'd0, "set_old");
      rd(12'h7c6, 32'd1, "set_new");
      acc(1'b0, 3'b011, 32'd1, 12'h7c6, 1'b1, 1'b1, 32'd1, "clr_old");
      rd(12'h7c6, 32'd0, "clr_new");
      wr(12'h7c2, 32'd77, "f_lo");
      wr(12'h7c3, 32'd0, "f_hi");
      idle(5);
      rd(12'h7c2, 32'd77, "freeze");

      // Writes coinciding with a tick.
      wr(12'h7c2, 32'd0, "t_lo");
      wr(12'h7c6, 32'd1, "t_en");
      idle(3);
      wr(12'h7c2, 32'd100, "t_w100");
      rd(12'h7c2, 32'd100, "tick_wr_a");
      rd(12'h7c2, 32'd101, "tick_wr_b");
      wr(12'h7c6, 32'd0, "dis");
      wr(12'h7c2, 32'hFFFF_FFFF, "h_lo");
      wr(12'h7c3, 32'd5, "h_hi");
      wr(12'h7c6, 32'd1, "h_en");
      wr(12'h7c3, 32'd9, "h_w9");
      rd(12'h7c3, 32'd9, "hiwr_hi");
      rd(12'h7c2, 32'd1, "hiwr_lo");
      wr(12'h7c6, 32'd0, "dis");
      wr(12'h7c3, 32'd2, "l_hi");
      wr(12'h7c2, 32'hFFFF_FFFF, "l_lo");
      wr(12'h7c6, 32'd1, "l_en");
      wr(12'h7c2, 32'd5, "l_w5");
      rd(12'h7c3, 32'd3, "lowr_hi");
      rd(12'h7c2, 32'd6, "lowr_lo");
      chk({63'd0, irq_timer}, 64'd1, "irq_pre_rst");

      // Asynchronous reset mid-operation.
      read = 1'b1;
      addr = 12'h7c2;
      rst  = 1'b1;
      #2;
      chk({63'd0, irq_timer}, 64'd0, "rst_async_irq");
      chk({32'd0, rdata}, 64'd0, "rst_async_mtime");
      read = 1'b0;
      addr = 12'h000;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd(12'h7c6, 32'h000B_0000, "rst_tctrl");
      rd(12'h7c4, 32'hFFFF_FFFF, "rst_cmp");

      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/csr_timer.md
Name: csr_timer

Overview:
- CSR-mapped RISC-V style machine timer: 64-bit mtime counter, 64-bit mtimecmp compare register and a programmable prescaler.
- Sits beside the counter and UART CSR units on the pipeline's CSR bus.
- Drives the pipeline's irq_timer input, which is currently tied to 0 in the top-level wrapper.
- rdata/valid are OR-combined with the other CSR units, so both are 0 when the block is not addressed.

Parameters:
- BASE_ADDR, 12'h7c2: CSR address of MTIME. Map: +0 MTIME, +1 MTIMEH, +2 MTIMECMP, +3 MTIMECMPH, +4 TCTRL.
- CLOCK_RATE, 12_000_000: clk frequency in Hz.
- TICK_RATE, 1_000_000: mtime increment rate in Hz after reset. Reset prescale value PRE_RST = CLOCK_RATE/TICK_RATE-1 must fit in 16 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- read  in  1  CSR read strobe
- modify  in  3  CSR write op: 3'b001 write, 3'b010 set bits, 3'b011 clear bits, other codes no write
- wdata  in  32  CSR write operand
- addr  in  12  CSR address
- rdata  out  32  read data of the addressed register; 0 when not addressed
- valid  out  1  this block claims the access
- irq_timer  out  1  timer interrupt request, level, registered

Behaviour:
- Reset: one asynchronous reset for all state. Values:
  - mtime = 0
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - TCTRL.en (bit 0) = 0, TCTRL.pre (bits 31:16) = PRE_RST
  - prescale counter = 0
  - irq_timer = 0
  - Combinational outputs rdata = 0 and valid = 0 while inputs are idle.
- Address hit: hit = addr in BASE_ADDR..BASE_ADDR+4. valid = hit & (read | modify!=0), combinational, same cycle. rdata = hit ? register : 0, regardless of read.
- TCTRL read view: {pre[15:0], 15'b0, en}. Write data to bits 15:1 is ignored.
- Writes:
  - new = write ? wdata : set ? old|wdata : clear ? old&~wdata.
  - Applied at the next rising clk edge.
  - rdata in the access cycle shows the old value, giving CSRRx read-old semantics.
  - A 32-bit write to one half leaves the other half unchanged.
- Prescaler:
  - When en=1, the counter counts 0..pre. When it equals pre, it wraps to 0 and a one-cycle tick fires.
  - pre=0 gives a tick every cycle.
  - When en=0, the counter holds at 0 and mtime holds.
  - A write to TCTRL clears the prescale counter.
- mtime:
  - Increments by 1 on tick and wraps from 2^64-1 to 0.
  - The carry from MTIME into MTIMEH is handled inside the 64-bit increment.
  - If a CSR write to MTIME or MTIMEH coincides with a tick, the written half takes the written value. The other half still receives the increment result, including the carry computed from the pre-write value.
- irq_timer:
  - Registered each cycle as en & (mtime_next >= mtimecmp_next), an unsigned 64-bit compare using post-update values. It asserts in the same edge that mtime reaches mtimecmp.
  - Stays high until software raises mtimecmp, lowers mtime, or clears en.
  - A cmp write that drops the condition deasserts irq at the write edge.
- Read of MTIMEH after MTIME is not atomic. Software uses the hi-lo-hi loop; no shadow latch is provided.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously), and a pending irq is dropped.

Test Plan:
- Reset, then wait 30 cycles with en=0 → mtime reads 0, irq_timer=0. A read at 0x7c6 returns {PRE_RST=16'd11, 16'h0000} with valid=1; addr 0x7c7 gives valid=0, rdata=0.
- Write TCTRL=32'h0000_0001 (pre=0, en=1) → mtime advances by 1 each cycle; after 10 cycles MTIME reads 10. With pre=3, MTIME advances once per 4 cycles.
- Write MTIME=32'hFFFF_FFFE, MTIMEH=0, pre=0, en=1 → after 2 ticks MTIME=0, MTIMEH=1 (carry). Separately, 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Set mtimecmp=20, mtime=0, pre=0, en → irq_timer rises on the edge where mtime becomes 20 and stays high. Writing MTIMECMPH=1 drops it on the next edge.
- Set/clear ops: TCTRL=0, then modify=3'b010 with wdata=1 → en=1. Then modify=3'b011 with wdata=1 → en=0 and mtime freezes. Read-old: rdata during the set cycle shows en=0.
- Write MTIME=100 in a tick cycle → the next read returns 100, not 101. Asserting rst while irq is high → irq_timer=0 and mtime=0 immediately.
